// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions for the write-back stage.
//   XLEN          default datapath width
//   result_src_e  write-back result source select
//   F3_*          load funct3 encodings
package riscv_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10,
        RES_IMM = 2'b11
    } result_src_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

endpackage

// File: rtl/load_ext.sv
// Load data extraction: selects the addressed byte/half/word/double out of
// the raw aligned memory word and sign- or zero-extends it to XLEN.
// Ports:
//   i_funct3    load funct3
//   i_offset    byte offset within the XLEN-wide word
//   i_raw       raw aligned memory word
//   o_data      extended load data (raw word for illegal funct3)
//   o_misalign  offset not naturally aligned for the access size
module load_ext
    import riscv_pkg::*;
#(
    parameter int XLEN = riscv_pkg::XLEN
) (
    input  logic [2:0]                  i_funct3,
    input  logic [$clog2(XLEN/8)-1:0]   i_offset,
    input  logic [XLEN-1:0]             i_raw,
    output logic [XLEN-1:0]             o_data,
    output logic                        o_misalign
);

    logic [XLEN-1:0] w_shifted;

    // Bring the addressed byte down to bit 0; the case below then only
    // has to pick a width and an extension.
    assign w_shifted = i_raw >> {i_offset, 3'b000};

    always_comb begin
        o_data     = i_raw;
        o_misalign = 1'b0;
        case (i_funct3)
            F3_LB:  o_data = XLEN'($signed(w_shifted[7:0]));
            F3_LBU: o_data = XLEN'(w_shifted[7:0]);
            F3_LH: begin
                o_data     = XLEN'($signed(w_shifted[15:0]));
                o_misalign = i_offset[0];
            end
            F3_LHU: begin
                o_data     = XLEN'(w_shifted[15:0]);
                o_misalign = i_offset[0];
            end
            F3_LW: begin
                o_data     = XLEN'($signed(w_shifted[31:0]));
                o_misalign = |i_offset[1:0];
            end
            // LWU and LD exist only on RV64; on RV32 they fall through to
            // the raw word with no misalignment flag.
            F3_LWU: begin
                if (XLEN == 64) begin
                    o_data     = XLEN'(w_shifted[31:0]);
                    o_misalign = |i_offset[1:0];
                end
            end
            F3_LD: begin
                if (XLEN == 64) begin
                    o_data     = w_shifted;
                    o_misalign = |i_offset;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: MEM/WB pipeline register, result select, load
// extraction and retired-instruction counter.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   StallW, FlushW           hold / bubble control for the MEM/WB register
//   ValidM ... RdM           M-stage instruction fields
//   ValidW, RegWriteW, RdW   W-stage instruction state and register write
//   ResultW                  selected write-back value
//   LoadMisalignW            W-stage load is not naturally aligned
//   InstRetW                 retired-instruction count (wraps)
//
// Pipeline control: on each rising edge FlushW=1 clears valid/regwrite
// (independent of StallW); otherwise StallW=1 holds the register and
// StallW=0 captures the M inputs. An instruction retires on an edge where
// it sits valid in W and StallW=0, whether or not FlushW is set.
module wb_stage
    import riscv_pkg::*;
#(
    parameter int XLEN  = riscv_pkg::XLEN,
    parameter int CNT_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              StallW,
    input  logic              FlushW,
    input  logic              ValidM,
    input  logic              RegWriteM,
    input  logic [1:0]        ResultSrcM,
    input  logic [2:0]        LoadTypeM,
    input  logic [XLEN-1:0]   ALUResultM,
    input  logic [XLEN-1:0]   ReadDataM,
    input  logic [XLEN-1:0]   PCPlus4M,
    input  logic [XLEN-1:0]   ImmExtM,
    input  logic [4:0]        RdM,
    output logic              ValidW,
    output logic              RegWriteW,
    output logic [XLEN-1:0]   ResultW,
    output logic [4:0]        RdW,
    output logic              LoadMisalignW,
    output logic [CNT_W-1:0]  InstRetW
);

    localparam int OFFW = $clog2(XLEN/8);

    logic              r_valid;
    logic              r_regwrite;
    result_src_e       r_src;
    logic [2:0]        r_ltype;
    logic [XLEN-1:0]   r_alu;
    logic [XLEN-1:0]   r_rdata;
    logic [XLEN-1:0]   r_pc4;
    logic [XLEN-1:0]   r_imm;
    logic [4:0]        r_rd;
    logic [CNT_W-1:0]  r_instret;

    logic [XLEN-1:0]   w_load_data;
    logic              w_load_mis;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid    <= 1'b0;
            r_regwrite <= 1'b0;
            r_src      <= RES_ALU;
            r_ltype    <= 3'b000;
            r_alu      <= '0;
            r_rdata    <= '0;
            r_pc4      <= '0;
            r_imm      <= '0;
            r_rd       <= 5'd0;
            r_instret  <= '0;
        end else begin
            // Counts the instruction leaving W, so a simultaneous flush of
            // the incoming slot does not hide it.
            if (r_valid && !StallW) begin
                r_instret <= r_instret + CNT_W'(1);
            end
            if (FlushW) begin
                r_valid    <= 1'b0;
                r_regwrite <= 1'b0;
            end else if (!StallW) begin
                r_valid    <= ValidM;
                r_regwrite <= RegWriteM;
                r_src      <= result_src_e'(ResultSrcM);
                r_ltype    <= LoadTypeM;
                r_alu      <= ALUResultM;
                r_rdata    <= ReadDataM;
                r_pc4      <= PCPlus4M;
                r_imm      <= ImmExtM;
                r_rd       <= RdM;
            end
        end
    end

    load_ext #(
        .XLEN (XLEN)
    ) u_load_ext (
        .i_funct3   (r_ltype),
        .i_offset   (r_alu[OFFW-1:0]),
        .i_raw      (r_rdata),
        .o_data     (w_load_data),
        .o_misalign (w_load_mis)
    );

    always_comb begin
        ResultW = r_alu;
        case (r_src)
            RES_ALU: ResultW = r_alu;
            RES_MEM: ResultW = w_load_data;
            RES_PC4: ResultW = r_pc4;
            RES_IMM: ResultW = r_imm;
            default: ResultW = r_alu;
        endcase
    end

    assign ValidW        = r_valid;
    assign RdW           = r_rd;
    assign InstRetW      = r_instret;
    assign LoadMisalignW = r_valid & (r_src == RES_MEM) & w_load_mis;
    // A misaligned load still retires but must not write the register file.
    assign RegWriteW     = r_regwrite & r_valid & (r_rd != 5'd0) & ~LoadMisalignW;

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;

    localparam int XLEN  = 32;
    localparam int CNT_W = 8;

    typedef struct packed {
        logic        valid;
        logic        regwrite;
        logic [1:0]  src;
        logic [2:0]  lt;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [31:0] pc4;
        logic [31:0] imm;
        logic [4:0]  rd;
    } txn_t;

    // ---------------- clock / reset / DUT ----------------
    logic              clk = 1'b0;
    logic              rst;
    logic              StallW, FlushW, ValidM, RegWriteM;
    logic [1:0]        ResultSrcM;
    logic [2:0]        LoadTypeM;
    logic [XLEN-1:0]   ALUResultM, ReadDataM, PCPlus4M, ImmExtM;
    logic [4:0]        RdM;
    logic              ValidW, RegWriteW, LoadMisalignW;
    logic [XLEN-1:0]   ResultW;
    logic [4:0]        RdW;
    logic [CNT_W-1:0]  InstRetW;

    always #5 clk = ~clk;

    wb_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .StallW(StallW), .FlushW(FlushW),
        .ValidM(ValidM), .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM),
        .LoadTypeM(LoadTypeM), .ALUResultM(ALUResultM), .ReadDataM(ReadDataM),
        .PCPlus4M(PCPlus4M), .ImmExtM(ImmExtM), .RdM(RdM),
        .ValidW(ValidW), .RegWriteW(RegWriteW), .ResultW(ResultW), .RdW(RdW),
        .LoadMisalignW(LoadMisalignW), .InstRetW(InstRetW)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    txn_t             mw;       // instruction currently in W
    logic [CNT_W-1:0] exp_cnt;  // expected retired count

    function automatic logic [31:0] exp_load(input txn_t t);
        int unsigned off;
        logic [31:0] sh, b, h;
        off = t.alu % 4;
        sh  = t.rdata >> (8 * off);
        b   = sh % 256;
        h   = sh % 65536;
        case (t.lt)
            3'd0: return (b >= 128) ? b - 32'd256 : b;
            3'd1: return (h >= 32768) ? h - 32'd65536 : h;
            3'd2: return sh;
            3'd4: return b;
            3'd5: return h;
            default: return t.rdata;
        endcase
    endfunction

    function automatic logic [31:0] exp_result(input txn_t t);
        case (t.src)
            2'd0: return t.alu;
            2'd1: return exp_load(t);
            2'd2: return t.pc4;
            default: return t.imm;
        endcase
    endfunction

    function automatic logic exp_mis(input txn_t t);
        int unsigned size;
        if (!t.valid || t.src != 2'd1) return 1'b0;
        if (t.lt == 3'd1 || t.lt == 3'd5) size = 2;
        else if (t.lt == 3'd2) size = 4;
        else size = 1;
        return ((t.alu % 4) % size) != 0;
    endfunction

    function automatic logic exp_rw(input txn_t t);
        return t.valid && t.regwrite && (t.rd != 5'd0) && !exp_mis(t);
    endfunction

    function automatic txn_t mk(input logic v, input logic rw, input logic [1:0] src,
                                input logic [2:0] lt, input logic [31:0] alu,
                                input logic [31:0] rdata, input logic [4:0] rd);
        txn_t t;
        t.valid = v; t.regwrite = rw; t.src = src; t.lt = lt;
        t.alu = alu; t.rdata = rdata; t.rd = rd;
        t.pc4 = $urandom; t.imm = $urandom;
        return t;
    endfunction

    function automatic txn_t rand_txn();
        txn_t t;
        t.valid    = ($urandom_range(0, 3) != 0);
        t.regwrite = $urandom_range(0, 1);
        t.src      = 2'($urandom_range(0, 3));
        t.lt       = 3'($urandom_range(0, 7));
        t.alu      = $urandom;
        t.rdata    = $urandom;
        t.pc4      = $urandom;
        t.imm      = $urandom;
        t.rd       = 5'($urandom_range(0, 31));
        return t;
    endfunction

    // ---------------- driver ----------------
    task automatic step(input txn_t t, input logic stall, input logic flush);
        ValidM = t.valid; RegWriteM = t.regwrite; ResultSrcM = t.src;
        LoadTypeM = t.lt; ALUResultM = t.alu; ReadDataM = t.rdata;
        PCPlus4M = t.pc4; ImmExtM = t.imm; RdM = t.rd;
        StallW = stall; FlushW = flush;
        @(posedge clk);
        if (!stall && mw.valid) exp_cnt = exp_cnt + 8'd1;
        if (flush) begin
            mw.valid = 1'b0;
            mw.regwrite = 1'b0;
        end else if (!stall) begin
            mw = t;
        end
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        txn_t t;
        rst = 1'b1;
        step(mk(0, 0, 2'd0, 3'd0, 32'd0, 32'd0, 5'd0), 1'b0, 1'b0);
        rst = 1'b0;
        #2;
        mw = '0; exp_cnt = '0;
        checks++; if (ValidW !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", ValidW); end
        checks++; if (RegWriteW !== 1'b0) begin errors++; $display("FAIL reset_regwrite got %b exp 0", RegWriteW); end
        checks++; if (LoadMisalignW !== 1'b0) begin errors++; $display("FAIL reset_misalign got %b exp 0", LoadMisalignW); end
        checks++; if (RdW !== 5'd0) begin errors++; $display("FAIL reset_rd got %h exp 0", RdW); end
        checks++; if (ResultW !== 32'd0) begin errors++; $display("FAIL reset_result got %h exp 0", ResultW); end
        checks++; if (InstRetW !== 8'd0) begin errors++; $display("FAIL reset_instret got %h exp 0", InstRetW); end
        @(negedge clk);
        rst = 1'b1;
        t = mk(1, 1, 2'd0, 3'd0, 32'h0000_5A5A, 32'd0, 5'd3);
        step(t, 1'b0, 1'b0);
        checks++; if (ValidW !== 1'b1) begin errors++; $display("FAIL first_capture_valid got %b exp 1", ValidW); end
        checks++; if (ResultW !== 32'h0000_5A5A) begin errors++; $display("FAIL first_capture_result got %h exp 00005a5a", ResultW); end
    endtask

    task automatic test_loads();
        logic [CNT_W-1:0] cnt_lh;
        step(mk(1, 1, 2'd1, 3'd0, 32'h0000_1003, 32'h80FF_7F01, 5'd7), 1'b0, 1'b0);
        checks++; if (ResultW !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_off3 got %h exp ffffff80", ResultW); end
        checks++; if (RegWriteW !== 1'b1) begin errors++; $display("FAIL lb_regwrite got %b exp 1", RegWriteW); end
        step(mk(1, 1, 2'd1, 3'd4, 32'h0000_2002, 32'h80FF_7F01, 5'd7), 1'b0, 1'b0);
        checks++; if (ResultW !== 32'h0000_00FF) begin errors++; $display("FAIL lbu_off2 got %h exp 000000ff", ResultW); end
        step(mk(1, 1, 2'd1, 3'd1, 32'h0000_0002, 32'hABCD_1234, 5'd8), 1'b0, 1'b0);
        checks++; if (ResultW !== 32'hFFFF_ABCD) begin errors++; $display("FAIL lh_off2 got %h exp ffffabcd", ResultW); end
        step(mk(1, 1, 2'd1, 3'd5, 32'h0000_0002, 32'hABCD_1234, 5'd8), 1'b0, 1'b0);
        checks++; if (ResultW !== 32'h0000_ABCD) begin errors++; $display("FAIL lhu_off2 got %h exp 0000abcd", ResultW); end
        step(mk(1, 1, 2'd1, 3'd2, 32'h0000_0004, 32'h8000_0001, 5'd8), 1'b0, 1'b0);
        checks++; if (ResultW !== 32'h8000_0001) begin errors++; $display("FAIL lw_aligned got %h exp 80000001", ResultW); end
        step(mk(1, 1, 2'd1, 3'd6, 32'h0000_0001, 32'h1357_9BDF, 5'd8), 1'b0, 1'b0);
        checks++; if (ResultW !== 32'h1357_9BDF) begin errors++; $display("FAIL lwu_rv32_raw got %h exp 13579bdf", ResultW); end
        checks++; if (LoadMisalignW !== 1'b0) begin errors++; $display("FAIL lwu_rv32_misalign got %b exp 0", LoadMisalignW); end
        step(mk(1, 1, 2'd1, 3'd1, 32'h0000_0001, 32'h1122_3344, 5'd5), 1'b0, 1'b0);
        cnt_lh = exp_cnt;
        checks++; if (LoadMisalignW !== 1'b1) begin errors++; $display("FAIL lh_misalign got %b exp 1", LoadMisalignW); end
        checks++; if (RegWriteW !== 1'b0) begin errors++; $display("FAIL lh_misalign_regwrite got %b exp 0", RegWriteW); end
        step(mk(1, 1, 2'd0, 3'd0, 32'h0000_1234, 32'd0, 5'd0), 1'b0, 1'b0);
        checks++; if (InstRetW !== cnt_lh + 8'd1) begin errors++; $display("FAIL misalign_retires got %h exp %h", InstRetW, cnt_lh + 8'd1); end
        checks++; if (ResultW !== 32'h0000_1234) begin errors++; $display("FAIL alu_rd0_result got %h exp 00001234", ResultW); end
        checks++; if (RegWriteW !== 1'b0) begin errors++; $display("FAIL alu_rd0_regwrite got %b exp 0", RegWriteW); end
        step(mk(1, 1, 2'd2, 3'd0, 32'd0, 32'd0, 5'd1), 1'b0, 1'b0);
        checks++; if (ResultW !== mw.pc4) begin errors++; $display("FAIL pc4_select got %h exp %h", ResultW, mw.pc4); end
        step(mk(1, 1, 2'd3, 3'd0, 32'd0, 32'd0, 5'd1), 1'b0, 1'b0);
        checks++; if (ResultW !== mw.imm) begin errors++; $display("FAIL imm_select got %h exp %h", ResultW, mw.imm); end
    endtask

    task automatic test_stall_flush();
        logic [CNT_W-1:0] held;
        txn_t a;
        a = mk(1, 1, 2'd0, 3'd0, 32'h0000_CAFE, 32'd0, 5'd9);
        step(a, 1'b0, 1'b0);
        held = exp_cnt;
        for (int i = 0; i < 3; i++) begin
            step(rand_txn(), 1'b1, 1'b0);
            checks++; if (ResultW !== 32'h0000_CAFE || RdW !== 5'd9 || ValidW !== 1'b1)
                begin errors++; $display("FAIL stall_hold[%0d] got %h/%0d/%b exp 0000cafe/9/1", i, ResultW, RdW, ValidW); end
            checks++; if (InstRetW !== held) begin errors++; $display("FAIL stall_instret[%0d] got %h exp %h", i, InstRetW, held); end
        end
        step(rand_txn(), 1'b1, 1'b1);
        checks++; if (ValidW !== 1'b0 || RegWriteW !== 1'b0) begin errors++; $display("FAIL flush_over_stall got %b/%b exp 0/0", ValidW, RegWriteW); end
        checks++; if (InstRetW !== held) begin errors++; $display("FAIL flush_stall_instret got %h exp %h", InstRetW, held); end
        step(a, 1'b0, 1'b0);
        held = exp_cnt;
        step(rand_txn(), 1'b0, 1'b1);
        checks++; if (InstRetW !== held + 8'd1) begin errors++; $display("FAIL flush_keeps_retire got %h exp %h", InstRetW, held + 8'd1); end
        checks++; if (ValidW !== 1'b0) begin errors++; $display("FAIL flush_valid got %b exp 0", ValidW); end
    endtask

    task automatic test_random();
        txn_t t;
        logic st, fl;
        for (int i = 0; i < 120; i++) begin
            t  = rand_txn();
            st = ($urandom_range(0, 4) == 0);
            fl = ($urandom_range(0, 7) == 0);
            step(t, st, fl);
            checks++; if (ValidW !== mw.valid) begin errors++; $display("FAIL rnd_valid[%0d] got %b exp %b", i, ValidW, mw.valid); end
            checks++; if (RegWriteW !== exp_rw(mw)) begin errors++; $display("FAIL rnd_regwrite[%0d] got %b exp %b", i, RegWriteW, exp_rw(mw)); end
            checks++; if (LoadMisalignW !== exp_mis(mw)) begin errors++; $display("FAIL rnd_misalign[%0d] got %b exp %b", i, LoadMisalignW, exp_mis(mw)); end
            checks++; if (InstRetW !== exp_cnt) begin errors++; $display("FAIL rnd_instret[%0d] got %h exp %h", i, InstRetW, exp_cnt); end
            if (mw.valid) begin
                checks++; if (RdW !== mw.rd) begin errors++; $display("FAIL rnd_rd[%0d] got %0d exp %0d", i, RdW, mw.rd); end
                if (!exp_mis(mw)) begin
                    checks++; if (ResultW !== exp_result(mw)) begin errors++; $display("FAIL rnd_result[%0d] got %h exp %h", i, ResultW, exp_result(mw)); end
                end
            end
        end
    endtask

    task automatic test_wrap();
        int n = 0;
        while (exp_cnt != 8'hFF && n < 300) begin
            step(mk(1, 1, 2'd0, 3'd0, $urandom, 32'd0, 5'd4), 1'b0, 1'b0);
            n++;
        end
        checks++; if (InstRetW !== 8'hFF) begin errors++; $display("FAIL wrap_preload got %h exp ff", InstRetW); end
        step(mk(0, 0, 2'd0, 3'd0, 32'd0, 32'd0, 5'd0), 1'b0, 1'b0);
        checks++; if (InstRetW !== 8'h00) begin errors++; $display("FAIL wrap_to_zero got %h exp 00", InstRetW); end
    endtask

    task automatic test_async_reset();
        step(mk(1, 1, 2'd1, 3'd1, 32'h0000_0003, 32'hFFFF_FFFF, 5'd6), 1'b0, 1'b0);
        step(mk(1, 1, 2'd0, 3'd0, 32'h0BAD_F00D, 32'd0, 5'd6), 1'b0, 1'b0);
        checks++; if (ValidW !== 1'b1) begin errors++; $display("FAIL async_pre_valid got %b exp 1", ValidW); end
        #2;
        rst = 1'b0;
        #1;
        mw = '0; exp_cnt = '0;
        checks++; if (ValidW !== 1'b0 || RegWriteW !== 1'b0 || LoadMisalignW !== 1'b0)
            begin errors++; $display("FAIL async_ctrl got %b%b%b exp 000", ValidW, RegWriteW, LoadMisalignW); end
        checks++; if (RdW !== 5'd0 || ResultW !== 32'd0) begin errors++; $display("FAIL async_data got %0d/%h exp 0/0", RdW, ResultW); end
        checks++; if (InstRetW !== 8'd0) begin errors++; $display("FAIL async_instret got %h exp 00", InstRetW); end
        #2;
        rst = 1'b1;
        step(mk(1, 1, 2'd0, 3'd0, 32'h0000_0077, 32'd0, 5'd2), 1'b0, 1'b0);
        checks++; if (ValidW !== 1'b1 || ResultW !== 32'h0000_0077) begin errors++; $display("FAIL post_reset_capture got %b/%h exp 1/00000077", ValidW, ResultW); end
        checks++; if (InstRetW !== 8'd0) begin errors++; $display("FAIL post_reset_instret got %h exp 00", InstRetW); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        mw = '0;
        exp_cnt = '0;
        test_reset();
        test_loads();
        test_stall_flush();
        test_random();
        test_wrap();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have parameter XLEN, default riscv_pkg::XLEN (32), write-back datapath width; legal values 32 and 64.
REQ-002 SHALL have parameter CNT_W, default 64, width of the retired-instruction counter.
REQ-003 SHALL have ports clk (input, 1, rising-edge clock) and rst (input, 1, asynchronous active-low reset).
REQ-004 SHALL have ports StallW (input, 1, hold MEM/WB contents) and FlushW (input, 1, load a bubble).
REQ-005 SHALL have ports ValidM (input, 1) and RegWriteM (input, 1).
REQ-006 SHALL have port ResultSrcM (input, 2): 00=ALU, 01=Mem, 10=PC+4, 11=ImmExt.
REQ-007 SHALL have port LoadTypeM (input, 3): RISC-V load funct3.
REQ-008 SHALL have ports ALUResultM, ReadDataM, PCPlus4M and ImmExtM (input, XLEN each); ReadDataM is the raw aligned memory word.
REQ-009 SHALL have port RdM (input, 5).
REQ-010 SHALL have ports ValidW and RegWriteW (output, 1 each), ResultW (output, XLEN) and RdW (output, 5).
REQ-011 SHALL have ports LoadMisalignW (output, 1) and InstRetW (output, CNT_W, retired-instruction count).

Function
REQ-012 The MEM/WB register SHALL capture all M-stage inputs on a rising edge when StallW=0 and FlushW=0.
REQ-013 With StallW=1 and FlushW=0, the register SHALL hold its contents.
REQ-014 FlushW=1 SHALL clear the captured valid and regwrite bits on the next edge regardless of StallW; FlushW has priority.
REQ-015 Latency SHALL be exactly one cycle from M inputs to W outputs.
REQ-016 ResultW SHALL be a combinational select of the registered ALU result, extended load data, PC+4 or ImmExt, per the registered ResultSrc.
REQ-017 Load extraction SHALL use byte offset = registered ALUResult[log2(XLEN/8)-1:0].
REQ-018 LB/LBU SHALL select the byte at that offset; LH/LHU the halfword; LW/LWU the word; LD (XLEN=64 only) the doubleword.
REQ-019 LB/LH/LW SHALL sign-extend to XLEN; LBU/LHU/LWU SHALL zero-extend.
REQ-020 LWU and LD SHALL be illegal when XLEN=32; illegal funct3 SHALL return the raw word.
REQ-021 LoadMisalignW SHALL equal ValidW & (ResultSrc==Mem) & offset not naturally aligned for the access size.
REQ-022 RegWriteW SHALL equal regwrite_q & ValidW & (RdW!=0) & ~LoadMisalignW.
REQ-023 InstRetW SHALL increment by 1 at each edge where ValidW=1 and StallW=0.
REQ-024 A misaligned load SHALL still count as retired.
REQ-025 InstRetW SHALL wrap modulo 2^CNT_W.
REQ-026 FlushW and StallW arriving in the same cycle as a retiring instruction SHALL NOT suppress that cycle's increment when StallW=0.

Reset
REQ-027 While rst=0, ValidW, RegWriteW and LoadMisalignW SHALL be 0.
REQ-028 While rst=0, RdW, all registered data and InstRetW SHALL be 0, so ResultW=0.
REQ-029 Reset asserted mid-operation SHALL take effect immediately, without waiting for a clock edge.
REQ-030 The first capture SHALL occur on the first rising edge after rst deasserts.

Structure
REQ-031 riscv_pkg SHALL hold result_src_e (RES_ALU, RES_MEM, RES_PC4, RES_IMM).
REQ-032 riscv_pkg SHALL hold the load funct3 constants (F3_LB..F3_LWU, F3_LD) and XLEN.
REQ-033 Load extraction SHALL be one combinational sub-module, load_ext (XLEN, funct3, offset, raw data -> extended data).
REQ-034 The MEM/WB register, mux and counter SHALL reside in wb_stage.

Verification
REQ-035 XLEN=32, LB with ReadDataM=32'h80FF_7F01 and offset 3 -> ResultW=32'hFFFF_FF80; LBU at offset 2 -> 32'h0000_00FF.
REQ-036 LH with offset 1 and RdM=5 -> LoadMisalignW=1, RegWriteW=0, InstRetW +1.
REQ-037 ALU op with RdM=0 and ALUResultM=32'h1234 -> ResultW=32'h1234 and RegWriteW=0.
REQ-038 StallW=1 for 3 cycles then FlushW=1 -> outputs held 3 cycles, InstRetW unchanged while stalled, ValidW=0 after the flush edge.
REQ-039 Preload InstRetW to 2^CNT_W-1 (CNT_W=8 build: 8'hFF) and retire one instruction -> InstRetW=0.
REQ-040 Assert rst=0 asynchronously mid-cycle with ValidW=1 -> all outputs 0 before the next clk edge.
